// File: rtl/sram_responder16b_pkg.sv
// Shared types and constants for the 16-bit SRAM responder and its test patterns.
package sram_responder16b_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    RDWAIT  = 2'd0,
    RDVALID = 2'd1,
    WRLOW   = 2'd2,
    WRDONE  = 2'd3
  } resp_state_e;

  localparam logic [DATA_W-1:0] PAT_INIT = 16'h7FFF;
  localparam logic [DATA_W-1:0] PAT_PASS = 16'h8000;

  // Write payload captured on every we_n-low cycle
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ub_n;
    logic              lb_n;
  } wr_payload_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sram_resp_bram.sv
// Single-port 16-bit block RAM with per-byte write enables and a registered read port.
module sram_resp_bram
  import sram_responder16b_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we[1]) mem[addr][15:8] <= wdata[15:8];
      if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    end
  end

  // Read register only updates on a read access, so it holds the last read word otherwise
  always_ff @(posedge clk) begin
    if (rst)                rdata <= '0;
    else if (en && we == '0) rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_responder16b.sv
// Block-RAM stand-in for the board's 16-bit async SRAM: read latency model,
// we_n-rising-edge write commit and master timing-violation flags.
module sram_responder16b
  import sram_responder16b_pkg::*;
#(
  parameter int unsigned AW         = 21,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 2,
  parameter int unsigned MIN_WE_LOW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     sram_a,
  input  logic [DATA_W-1:0] sram_d_wr,
  output logic [DATA_W-1:0] sram_d_rd,
  input  logic              sram_we_n,
  input  logic              sram_ub_n,
  input  logic              sram_lb_n,
  output logic              rd_valid,
  output logic              viol_we_short,
  output logic              viol_addr_chg,
  output logic [7:0]        err_count
);

  logic [AW-1:0]         a_q, a_p;
  logic [DATA_W-1:0]     d_q;
  logic                  we_q, ub_q, lb_q;

  resp_state_e           state;
  logic [CNT_W-1:0]      cnt;
  logic                  abort;
  logic [DEPTH_LOG2-1:0] wr_a;
  wr_payload_t           wr_pl;

  logic                  addr_chg;
  logic                  rd_go;
  logic                  wr_ok;
  logic                  bram_en;
  logic [1:0]            bram_we;
  logic [DEPTH_LOG2-1:0] bram_addr;
  logic [7:0]            err_next;

  // Input capture; a_p keeps the previous captured address for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      a_p  <= '0;
      d_q  <= '0;
      we_q <= 1'b1;
      ub_q <= 1'b1;
      lb_q <= 1'b1;
    end else begin
      a_q  <= sram_a;
      a_p  <= a_q;
      d_q  <= sram_d_wr;
      we_q <= sram_we_n;
      ub_q <= sram_ub_n;
      lb_q <= sram_lb_n;
    end
  end

  always_comb begin
    addr_chg  = (a_q != a_p);
    rd_go     = (state == RDWAIT) && we_q && !addr_chg &&
                (cnt == CNT_W'(READ_LAT - 1));
    wr_ok     = (state == WRDONE) && !abort && !rst &&
                (cnt >= CNT_W'(MIN_WE_LOW));
    bram_we   = {2{wr_ok}} & {~wr_pl.ub_n, ~wr_pl.lb_n};
    bram_en   = rd_go || wr_ok;
    bram_addr = (state == WRDONE) ? wr_a : a_q[DEPTH_LOG2-1:0];
    err_next  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RDWAIT;
      cnt           <= '0;
      abort         <= 1'b0;
      wr_a          <= '0;
      wr_pl         <= '0;
      rd_valid      <= 1'b0;
      viol_we_short <= 1'b0;
      viol_addr_chg <= 1'b0;
      err_count     <= '0;
    end else begin
      viol_we_short <= 1'b0;
      viol_addr_chg <= 1'b0;
      case (state)
        RDWAIT, RDVALID: begin
          if (!we_q) begin
            // A falling strobe abandons any read in progress
            state    <= WRLOW;
            cnt      <= CNT_W'(1);
            abort    <= 1'b0;
            rd_valid <= 1'b0;
            wr_a     <= a_q[DEPTH_LOG2-1:0];
            wr_pl    <= '{data: d_q, ub_n: ub_q, lb_n: lb_q};
          end else if (addr_chg) begin
            state    <= RDWAIT;
            cnt      <= '0;
            rd_valid <= 1'b0;
          end else if (rd_go) begin
            state    <= RDVALID;
            rd_valid <= 1'b1;
          end else if (state == RDWAIT) begin
            cnt <= cnt_sat_inc(cnt);
          end
        end
        WRLOW: begin
          if (!we_q) begin
            cnt   <= cnt_sat_inc(cnt);
            wr_a  <= a_q[DEPTH_LOG2-1:0];
            wr_pl <= '{data: d_q, ub_n: ub_q, lb_n: lb_q};
            if (addr_chg) abort <= 1'b1;
          end else begin
            state <= WRDONE;
            // An address change outranks a short pulse; either costs one error
            if (abort) begin
              viol_addr_chg <= 1'b1;
              err_count     <= err_next;
            end else if (cnt < CNT_W'(MIN_WE_LOW)) begin
              viol_we_short <= 1'b1;
              err_count     <= err_next;
            end
          end
        end
        WRDONE: begin
          state <= RDWAIT;
          cnt   <= '0;
        end
        default: state <= RDWAIT;
      endcase
    end
  end

  sram_resp_bram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bram (
    .clk  (clk),
    .rst  (rst),
    .en   (bram_en),
    .we   (bram_we),
    .addr (bram_addr),
    .wdata(wr_pl.data),
    .rdata(sram_d_rd)
  );

endmodule

// File: tb/tb_sram_responder16b.sv
// Directed bench for sram_responder16b with a word-array memory model and a per-cycle read-data monitor.
module tb_sram_responder16b;
  import sram_responder16b_pkg::*;

  localparam int unsigned AW    = 21;
  localparam int unsigned DL    = 10;
  localparam int unsigned RL    = 2;
  localparam int unsigned MWL   = 2;
  localparam int unsigned DEPTH = 1 << DL;

  logic          clk;
  logic          rst;
  logic [AW-1:0] sram_a;
  logic [15:0]   sram_d_wr;
  logic [15:0]   sram_d_rd;
  logic          sram_we_n, sram_ub_n, sram_lb_n;
  logic          rd_valid, viol_we_short, viol_addr_chg;
  logic [7:0]    err_count;

  sram_responder16b #(
    .AW(AW), .DEPTH_LOG2(DL), .READ_LAT(RL), .MIN_WE_LOW(MWL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sram_a       (sram_a),
    .sram_d_wr    (sram_d_wr),
    .sram_d_rd    (sram_d_rd),
    .sram_we_n    (sram_we_n),
    .sram_ub_n    (sram_ub_n),
    .sram_lb_n    (sram_lb_n),
    .rd_valid     (rd_valid),
    .viol_we_short(viol_we_short),
    .viol_addr_chg(viol_addr_chg),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: word array indexed by the low address bits (upper bits alias)
  logic [15:0] mem_m [DEPTH];
  bit          known [DEPTH];
  int          exp_err = 0;
  int          n_short = 0;
  int          n_chg   = 0;
  bit          prev_short = 1'b0;
  bit          prev_chg   = 1'b0;
  logic [AW-1:0] last_samp = '0;
  logic [AW-1:0] prev_samp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a[DL-1:0]);
  endfunction

  always @(posedge clk) begin
    prev_samp = last_samp;
    last_samp = sram_a;
  end

  // Whenever rd_valid is up, the data must be the model word at the stable address
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid && known[idx(prev_samp)])
        chk("rd_data_vs_model", {16'h0, sram_d_rd}, {16'h0, mem_m[idx(prev_samp)]});
      if (viol_we_short || viol_addr_chg)
        chk("viol_exclusive", {31'h0, viol_we_short & viol_addr_chg}, 32'h0);
      if (viol_we_short) begin
        chk("viol_short_width", {31'h0, prev_short}, 32'h0);
        n_short++;
      end
      if (viol_addr_chg) begin
        chk("viol_chg_width", {31'h0, prev_chg}, 32'h0);
        n_chg++;
      end
      prev_short = viol_we_short;
      prev_chg   = viol_addr_chg;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    sram_we_n = 1'b1;
    exp_err   = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic ub_n,
                    input logic lb_n, input int low, input bit chg, input logic [AW-1:0] a2);
    int s0, c0;
    bit e_short, e_chg;
    int i;
    s0 = n_short;
    c0 = n_chg;
    @(negedge clk);
    sram_a = a; sram_d_wr = d; sram_ub_n = ub_n; sram_lb_n = lb_n; sram_we_n = 1'b1;
    for (int k = 0; k < low; k++) begin
      @(negedge clk);
      sram_we_n = 1'b0;
      if (chg && k == 1) sram_a = a2;
    end
    @(negedge clk);
    sram_we_n = 1'b1;
    repeat (3) @(negedge clk);
    e_chg   = chg && (low > 1);
    e_short = !e_chg && (low < int'(MWL));
    if (e_chg || e_short) begin
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    end else begin
      i = idx(a);
      if (!lb_n) mem_m[i][7:0]  = d[7:0];
      if (!ub_n) mem_m[i][15:8] = d[15:8];
      known[i] = known[i] | (!ub_n && !lb_n);
    end
    chk("wr_short_pulses", n_short - s0, {31'h0, e_short});
    chk("wr_chg_pulses", n_chg - c0, {31'h0, e_chg});
    chk("err_count_model", {24'h0, err_count}, exp_err);
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [15:0] d);
    bit got;
    got = 1'b0;
    d   = 'x;
    @(negedge clk);
    sram_a = a; sram_we_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        d   = sram_d_rd;
        got = 1'b1;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL rd_timeout: addr %0h rd_valid 0 after 20 cycles, required 1", a);
    end
  endtask

  logic [15:0] v;
  int          bad;

  initial begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      known[k] = 1'b0;
      mem_m[k] = '0;
    end
    rst = 1'b1; sram_a = '0; sram_d_wr = '0;
    sram_we_n = 1'b1; sram_ub_n = 1'b1; sram_lb_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_d_rd", {16'h0, sram_d_rd}, 32'h0);
    chk("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("reset_viol_short", {31'h0, viol_we_short}, 32'h0);
    chk("reset_viol_chg", {31'h0, viol_addr_chg}, 32'h0);
    chk("reset_err_count", {24'h0, err_count}, 32'h0);
    rst = 1'b0;

    // Basic write then read-back
    wr(21'h00005, 16'h1234, 1'b0, 1'b0, 3, 1'b0, '0);
    chk("rd_valid_low_after_wr", {31'h0, rd_valid}, 32'h0);
    rd(21'h00005, v);
    chk("rd_1234", {16'h0, v}, 32'h1234);

    // Lower-lane-only overwrite
    wr(21'h7, 16'hAAAA, 1'b0, 1'b0, 2, 1'b0, '0);
    wr(21'h7, 16'h55FF, 1'b1, 1'b0, 2, 1'b0, '0);
    rd(21'h7, v);
    chk("rd_lane_merge", {16'h0, v}, 32'hAAFF);

    // Short write pulse
    do_reset();
    wr(21'h3, 16'h0000, 1'b0, 1'b0, 2, 1'b0, '0);
    wr(21'h3, 16'hFFFF, 1'b0, 1'b0, 1, 1'b0, '0);
    chk("short_err_count", {24'h0, err_count}, 32'd1);
    rd(21'h3, v);
    chk("rd_after_short", {16'h0, v}, 32'h0000);

    // Address change while we_n low
    do_reset();
    wr(21'h9,  16'h1111, 1'b0, 1'b0, 2, 1'b0, '0);
    wr(21'hA,  16'h2222, 1'b0, 1'b0, 2, 1'b0, '0);
    wr(21'h9,  16'h3333, 1'b0, 1'b0, 2, 1'b1, 21'hA);
    chk("chg_err_count", {24'h0, err_count}, 32'd1);
    rd(21'h9, v);
    chk("rd_9_untouched", {16'h0, v}, 32'h1111);
    rd(21'hA, v);
    chk("rd_10_untouched", {16'h0, v}, 32'h2222);

    // Both lanes disabled is a legal no-op
    wr(21'h5, 16'hFFFF, 1'b1, 1'b1, 2, 1'b0, '0);
    chk("noop_err_count", {24'h0, err_count}, 32'd1);
    rd(21'h5, v);
    chk("rd_noop", {16'h0, v}, 32'h1234);

    // Error counter saturation
    for (int k = 0; k < 300; k++) wr(21'hB, 16'(k), 1'b0, 1'b0, 1, 1'b0, '0);
    chk("err_saturated", {24'h0, err_count}, 32'd255);

    // Reset in the middle of a write low phase discards it
    @(negedge clk);
    sram_a = 21'h5; sram_d_wr = 16'hBEEF; sram_ub_n = 1'b0; sram_lb_n = 1'b0;
    @(negedge clk);
    sram_we_n = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_err = 0;
    @(negedge clk);
    chk("midwr_rst_d_rd", {16'h0, sram_d_rd}, 32'h0);
    chk("midwr_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("midwr_rst_err", {24'h0, err_count}, 32'h0);
    sram_we_n = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(21'h5, v);
    chk("rd_after_midwr_rst", {16'h0, v}, 32'h1234);

    // Full pattern pass over the whole array
    do_reset();
    for (int k = 0; k < int'(DEPTH); k++) wr(AW'(k), PAT_INIT, 1'b0, 1'b0, 2, 1'b0, '0);
    for (int k = 0; k < int'(DEPTH); k++) begin
      rd(AW'(k), v);
      wr(AW'(k), v + 16'd1, 1'b0, 1'b0, 2, 1'b0, '0);
    end
    bad = 0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      rd(AW'(k), v);
      if (v !== 16'h8000) bad++;
    end
    chk("full_pass_bad_words", bad, 32'h0);
    chk("full_pass_err", {24'h0, err_count}, 32'h0);
    rd(21'h00400, v);
    chk("alias_read_0x400", {16'h0, v}, 32'h8000);
    wr(21'h00400, 16'h1357, 1'b0, 1'b0, 2, 1'b0, '0);
    rd(21'h00000, v);
    chk("alias_write_hits_0", {16'h0, v}, 32'h1357);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
